// File: rtl/crossbar_nxm_write_arb_pkg.sv
// ----------------------------------------------------------------------------
// crossbar_nxm_write_arb_pkg
// Shared parameter header for the LSU <-> bank-group crossbars (write and read).
// Provides the default crossbar dimensions, the bank-select width helper and
// the packed LSU write-request layout {sel, data}.
// No ports.
// ----------------------------------------------------------------------------
package crossbar_nxm_write_arb_pkg;

  // Width of an index field for n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int XBAR_N_LSU_DEF  = 8;
  localparam int XBAR_N_BG_DEF   = 8;
  localparam int XBAR_W_DATA_DEF = 32;
  localparam int XBAR_SEL_W_DEF  = clog2_min1(XBAR_N_BG_DEF);

  // One LSU write request as carried on the flattened request buses.
  typedef struct packed {
    logic [XBAR_SEL_W_DEF-1:0]  sel;
    logic [XBAR_W_DATA_DEF-1:0] data;
  } lsu_wreq_t;

endpackage

// File: rtl/crossbar_nxm_write_arb_arb.sv
// ----------------------------------------------------------------------------
// xbar_rr_arb
// Single-bank arbiter: picks one requester out of N and returns a one-hot
// grant. With XBAR_WR_RR_ARB_EN defined it is a round-robin arbiter whose
// pointer moves to the slot after the winner whenever advance_i is high;
// otherwise it is a stateless fixed-priority arbiter (lowest index wins).
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset (pointer only)
//   req_i       request vector, one bit per requester
//   advance_i   a grant is actually taken this cycle; move the pointer
//   gnt_o       one-hot grant (all zero when no request)
// ----------------------------------------------------------------------------
module xbar_rr_arb
  import crossbar_nxm_write_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

`ifdef XBAR_WR_RR_ARB_EN
  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            best_d, win_k, d;

  // The winner is the requester closest to the pointer going upwards,
  // measured as (k - ptr) mod N; ties are impossible.
  always_comb begin
    gnt_o  = '0;
    found  = 1'b0;
    best_d = N;
    win_k  = 0;
    d      = 0;
    for (int k = 0; k < N; k++) begin
      d = k - int'(ptr_q);
      if (d < 0) d = d + N;
      if (req_i[k] && (d < best_d)) begin
        best_d = d;
        win_k  = k;
        found  = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      gnt_o[k] = found && (win_k == k);
    end
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (win_k == N - 1) ? '0 : PW'(win_k + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic found;
  logic unused_ok;

  // Fixed priority needs no state; clock, reset and advance are unused.
  assign unused_ok = ^{clk, rst_n, advance_i};

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/crossbar_nxm_write_arb.sv
// ----------------------------------------------------------------------------
// crossbar_nxm_write_arb
// N-LSU to M-bank-group write crossbar. Each bank group has its own arbiter
// (xbar_rr_arb) choosing among the LSUs that target it; the winner's data is
// loaded into a per-bank output register one cycle later. A bank whose output
// register holds an unconsumed write (bg_w_en=1, bg_w_ready=0) makes no grant.
// Requests with an out-of-range bank select are consumed without a write and
// set the sticky sel_err flag.
// Arbitration: round-robin when XBAR_WR_RR_ARB_EN is defined, otherwise fixed
// priority (lowest LSU index wins).
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   lsu_w_valid  per-LSU request valid
//   lsu_w_sel    per-LSU target bank group, LSU i at [i*SEL_W +: SEL_W]
//   lsu_w_data   per-LSU write data, LSU i at [i*W_DATA +: W_DATA]
//   lsu_w_ready  per-LSU accept (combinational)
//   bg_w_en      registered per-bank write enable
//   bg_w_data    registered per-bank write data, bank b at [b*W_DATA +: W_DATA]
//   bg_w_ready   per-bank consume strobe
//   sel_err      sticky out-of-range select flag
// ----------------------------------------------------------------------------
module crossbar_nxm_write_arb
  import crossbar_nxm_write_arb_pkg::*;
#(
  parameter int N_LSU  = XBAR_N_LSU_DEF,
  parameter int N_BG   = XBAR_N_BG_DEF,
  parameter int W_DATA = XBAR_W_DATA_DEF,
  parameter int SEL_W  = clog2_min1(N_BG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_LSU-1:0]        lsu_w_valid,
  input  logic [N_LSU*SEL_W-1:0]  lsu_w_sel,
  input  logic [N_LSU*W_DATA-1:0] lsu_w_data,
  output logic [N_LSU-1:0]        lsu_w_ready,
  output logic [N_BG-1:0]         bg_w_en,
  output logic [N_BG*W_DATA-1:0]  bg_w_data,
  input  logic [N_BG-1:0]         bg_w_ready,
  output logic                    sel_err
);

  logic [N_BG-1:0][N_LSU-1:0] bank_req;
  logic [N_BG-1:0][N_LSU-1:0] bank_gnt;
  logic [N_LSU-1:0]           oor;
  logic [N_BG-1:0]            slot_free;

  logic [N_BG-1:0]            en_q, en_d;
  logic [N_BG*W_DATA-1:0]     data_q, data_d;
  logic                       sel_err_q, sel_err_d;

  // Decode each valid request into a per-bank request vector, or flag it as
  // out of range (only reachable when N_BG is not a power of two).
  always_comb begin
    bank_req = '0;
    oor      = '0;
    for (int i = 0; i < N_LSU; i++) begin
      if (lsu_w_valid[i]) begin
        if (32'(lsu_w_sel[i*SEL_W +: SEL_W]) >= N_BG) begin
          oor[i] = 1'b1;
        end else begin
          for (int b = 0; b < N_BG; b++) begin
            if (lsu_w_sel[i*SEL_W +: SEL_W] == SEL_W'(b)) bank_req[b][i] = 1'b1;
          end
        end
      end
    end
  end

  // A slot can take a new write when empty or when its current write is
  // consumed this very cycle, giving back-to-back reloads with no bubble.
  assign slot_free = ~en_q | bg_w_ready;

  for (genvar b = 0; b < N_BG; b++) begin : g_bank
    xbar_rr_arb #(.N(N_LSU)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (bank_req[b]),
      .advance_i (slot_free[b] & (|bank_req[b])),
      .gnt_o     (bank_gnt[b])
    );
  end

  // Grant gating, ready generation and output register next state.
  always_comb begin
    lsu_w_ready = oor;
    en_d        = en_q;
    data_d      = data_q;
    sel_err_d   = sel_err_q | (|oor);
    for (int b = 0; b < N_BG; b++) begin
      if (slot_free[b]) begin
        en_d[b] = |bank_req[b];
        for (int i = 0; i < N_LSU; i++) begin
          if (bank_gnt[b][i]) begin
            data_d[b*W_DATA +: W_DATA] = lsu_w_data[i*W_DATA +: W_DATA];
            lsu_w_ready[i]             = 1'b1;
          end
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bg_w_en   = en_q;
  assign bg_w_data = data_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_crossbar_nxm_write_arb.sv
module tb_crossbar_nxm_write_arb;
  localparam int NL = 8;
  localparam int NB = 8;
  localparam int NB6 = 6;
  localparam int W  = 32;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance, 8 bank groups
  logic [NL-1:0]    v;
  logic [NL*SW-1:0] sel;
  logic [NL*W-1:0]  dat;
  logic [NL-1:0]    rdy;
  logic [NB-1:0]    en;
  logic [NB*W-1:0]  bdat;
  logic [NB-1:0]    bgr;
  logic             serr;

  // Second instance, 6 bank groups (out-of-range selects possible)
  logic [NL-1:0]    v6;
  logic [NL*SW-1:0] sel6;
  logic [NL*W-1:0]  dat6;
  logic [NL-1:0]    rdy6;
  logic [NB6-1:0]   en6;
  logic [NB6*W-1:0] bdat6;
  logic [NB6-1:0]   bgr6;
  logic             serr6;

  crossbar_nxm_write_arb #(.N_LSU(NL), .N_BG(NB), .W_DATA(W), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_w_valid(v), .lsu_w_sel(sel), .lsu_w_data(dat), .lsu_w_ready(rdy),
    .bg_w_en(en), .bg_w_data(bdat), .bg_w_ready(bgr), .sel_err(serr)
  );

  crossbar_nxm_write_arb #(.N_LSU(NL), .N_BG(NB6), .W_DATA(W), .SEL_W(SW)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .lsu_w_valid(v6), .lsu_w_sel(sel6), .lsu_w_data(dat6), .lsu_w_ready(rdy6),
    .bg_w_en(en6), .bg_w_data(bdat6), .bg_w_ready(bgr6), .sel_err(serr6)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected write data per bank, in acceptance order.
  logic [W-1:0] sbq [NB][$];

  task automatic clr_inputs();
    v = '0; sel = '0; dat = '0;
    v6 = '0; sel6 = '0; dat6 = '0;
  endtask

  task automatic set_lsu(input int i, input logic [SW-1:0] s, input logic [W-1:0] d);
    v[i] = 1'b1;
    sel[i*SW +: SW] = s;
    dat[i*W +: W] = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clr_inputs();
    bgr = '1; bgr6 = '1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (en !== '0) begin failures++; $display("FAIL reset_en got=%h want=0", en); end
    checks++; if (bdat !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", bdat); end
    checks++; if (serr !== 1'b0) begin failures++; $display("FAIL reset_selerr got=%b want=0", serr); end
    @(negedge clk);
    rst_n = 1'b1;
    bgr = '0;
    set_lsu(3, 3'd3, 32'hDEAD0003);
    #1;
    checks++; if (rdy !== 8'h08) begin failures++; $display("FAIL midrst_ready got=%h want=08", rdy); end
    @(posedge clk); #1;
    checks++; if (en !== 8'h08) begin failures++; $display("FAIL midrst_en got=%h want=08", en); end
    checks++; if (bdat[3*W +: W] !== 32'hDEAD0003) begin failures++; $display("FAIL midrst_data got=%h want=dead0003", bdat[3*W +: W]); end
    @(negedge clk);
    v = '0;
    #1;
    checks++; if (rdy !== 8'h00) begin failures++; $display("FAIL stall_ready got=%h want=00", rdy); end
    @(posedge clk); #1;
    checks++; if (en !== 8'h08) begin failures++; $display("FAIL stall_hold_en got=%h want=08", en); end
    // Asynchronous reset, well away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    checks++; if (en !== '0) begin failures++; $display("FAIL async_rst_en got=%h want=0", en); end
    checks++; if (bdat !== '0) begin failures++; $display("FAIL async_rst_data got=%h want=0", bdat); end
    checks++; if (serr !== 1'b0) begin failures++; $display("FAIL async_rst_selerr got=%b want=0", serr); end
    @(negedge clk);
    rst_n = 1'b1;
    clr_inputs();
    bgr = '1;
  endtask

  task automatic test_no_conflict();
    @(negedge clk);
    bgr = '1;
    for (int i = 0; i < NL; i++) set_lsu(i, SW'(i), 32'hA0 + i);
    #1;
    checks++; if (rdy !== 8'hFF) begin failures++; $display("FAIL noconf_ready got=%h want=ff", rdy); end
    @(posedge clk); #1;
    checks++; if (en !== 8'hFF) begin failures++; $display("FAIL noconf_en got=%h want=ff", en); end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (bdat[b*W +: W] !== 32'hA0 + b) begin
        failures++; $display("FAIL noconf_data bank=%0d got=%h want=%h", b, bdat[b*W +: W], 32'hA0 + b);
      end
    end
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic test_conflict();
    int order [4];
    logic [W-1:0] want;
`ifdef XBAR_WR_RR_ARB_EN
    order = '{1, 4, 6, 1};
`else
    order = '{1, 1, 1, 1};
`endif
    pulse_reset();
    @(negedge clk);
    bgr = '1;
    set_lsu(1, 3'd2, 32'hB1);
    set_lsu(4, 3'd2, 32'hB4);
    set_lsu(6, 3'd2, 32'hB6);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (rdy !== (8'h01 << order[c])) begin
        failures++; $display("FAIL conflict_ready cycle=%0d got=%h want=%h", c, rdy, 8'h01 << order[c]);
      end
      sbq[2].push_back(32'hB0 + order[c]);
      @(posedge clk); #1;
      want = sbq[2].pop_front();
      checks++; if (en[2] !== 1'b1) begin failures++; $display("FAIL conflict_en cycle=%0d got=%b want=1", c, en[2]); end
      checks++;
      if (bdat[2*W +: W] !== want) begin
        failures++; $display("FAIL conflict_data cycle=%0d got=%h want=%h", c, bdat[2*W +: W], want);
      end
    end
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d1, d2;
    d1 = 32'h1111_D001;
    d2 = 32'h2222_D002;
    pulse_reset();
    @(negedge clk);
    bgr = '1;
    set_lsu(0, 3'd5, d1);
    set_lsu(2, 3'd5, d2);
    #1;
    checks++; if (rdy !== 8'h01) begin failures++; $display("FAIL bp_first_ready got=%h want=01", rdy); end
    @(posedge clk); #1;
    checks++; if (bdat[5*W +: W] !== d1) begin failures++; $display("FAIL bp_first_data got=%h want=%h", bdat[5*W +: W], d1); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      v[0] = 1'b0;
      bgr[5] = 1'b0;
      #1;
      checks++; if (rdy !== 8'h00) begin failures++; $display("FAIL bp_stall_ready cycle=%0d got=%h want=00", c, rdy); end
      @(posedge clk); #1;
      checks++;
      if (en[5] !== 1'b1 || bdat[5*W +: W] !== d1) begin
        failures++; $display("FAIL bp_hold cycle=%0d got_en=%b got=%h want=%h", c, en[5], bdat[5*W +: W], d1);
      end
    end
    @(negedge clk);
    bgr[5] = 1'b1;
    #1;
    checks++; if (rdy !== 8'h04) begin failures++; $display("FAIL bp_release_ready got=%h want=04", rdy); end
    @(posedge clk); #1;
    checks++;
    if (en[5] !== 1'b1 || bdat[5*W +: W] !== d2) begin
      failures++; $display("FAIL bp_second got_en=%b got=%h want=%h", en[5], bdat[5*W +: W], d2);
    end
    @(negedge clk);
    clr_inputs();
    @(posedge clk); #1;
    checks++; if (en[5] !== 1'b0) begin failures++; $display("FAIL bp_idle_en got=%b want=0", en[5]); end
  endtask

  task automatic test_sel_err();
    @(negedge clk);
    checks++; if (serr6 !== 1'b0) begin failures++; $display("FAIL selerr_init got=%b want=0", serr6); end
    bgr6 = '1;
    v6[3] = 1'b1;
    sel6[3*SW +: SW] = 3'd7;
    dat6[3*W +: W] = 32'h7777_0003;
    #1;
    checks++; if (rdy6 !== 8'h08) begin failures++; $display("FAIL selerr_ready got=%h want=08", rdy6); end
    @(posedge clk); #1;
    checks++; if (en6 !== 6'h00) begin failures++; $display("FAIL selerr_no_write got=%h want=00", en6); end
    checks++; if (serr6 !== 1'b1) begin failures++; $display("FAIL selerr_set got=%b want=1", serr6); end
    @(negedge clk);
    v6 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (serr6 !== 1'b1) begin failures++; $display("FAIL selerr_sticky got=%b want=1", serr6); end
    pulse_reset();
    #1;
    checks++; if (serr6 !== 1'b0) begin failures++; $display("FAIL selerr_reset got=%b want=0", serr6); end
  endtask

  task automatic test_random();
    logic           pend [NL];
    logic           en_m [NB];
    int             ptr_m [NB];
    logic [NL-1:0]  exp_rdy;
    logic [W-1:0]   want;
    int             w, k;
    bit             drain;
    pulse_reset();
    for (int i = 0; i < NL; i++) pend[i] = 1'b0;
    for (int b = 0; b < NB; b++) begin en_m[b] = 1'b0; ptr_m[b] = 0; end
    for (int cyc = 0; cyc < 10020; cyc++) begin
      drain = (cyc >= 10000);
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        if (!pend[i] && !drain && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          sel[i*SW +: SW] = SW'($urandom_range(NB - 1, 0));
          dat[i*W +: W] = $urandom;
        end
        v[i] = pend[i];
      end
      for (int b = 0; b < NB; b++) bgr[b] = drain ? 1'b1 : ($urandom_range(3, 0) != 0);
      #1;
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (en[b] !== en_m[b]) begin
          failures++; $display("FAIL rand_en cycle=%0d bank=%0d got=%b want=%b", cyc, b, en[b], en_m[b]);
        end
      end
      exp_rdy = '0;
      for (int b = 0; b < NB; b++) begin
        if (en_m[b] && bgr[b]) begin
          checks++;
          if (sbq[b].size() == 0) begin
            failures++; $display("FAIL rand_unexpected_write cycle=%0d bank=%0d got=%h want=none", cyc, b, bdat[b*W +: W]);
          end else begin
            want = sbq[b].pop_front();
            if (bdat[b*W +: W] !== want) begin
              failures++; $display("FAIL rand_data cycle=%0d bank=%0d got=%h want=%h", cyc, b, bdat[b*W +: W], want);
            end
          end
        end
        if (!en_m[b] || bgr[b]) begin
          w = -1;
          for (int j = 0; j < NL; j++) begin
`ifdef XBAR_WR_RR_ARB_EN
            k = (ptr_m[b] + j) % NL;
`else
            k = j;
`endif
            if (w < 0 && pend[k] && (int'(sel[k*SW +: SW]) == b)) w = k;
          end
          if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            sbq[b].push_back(dat[w*W +: W]);
            en_m[b] = 1'b1;
            ptr_m[b] = (w + 1) % NL;
          end else begin
            en_m[b] = 1'b0;
          end
        end
      end
      checks++;
      if (rdy !== exp_rdy) begin
        failures++; $display("FAIL rand_ready cycle=%0d got=%h want=%h", cyc, rdy, exp_rdy);
      end
      for (int i = 0; i < NL; i++) if (exp_rdy[i]) pend[i] = 1'b0;
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (sbq[b].size() != 0) begin
        failures++; $display("FAIL rand_lost bank=%0d got=%0d_pending want=0", b, sbq[b].size());
      end
    end
    @(negedge clk);
    clr_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    clr_inputs();
    bgr = '1;
    bgr6 = '1;
    test_reset();
    test_no_conflict();
    test_conflict();
    test_backpressure();
    test_sel_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
